uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame, LSB first.
REQ-002 Parameter PARITY_EN, default 0, 1 inserts a parity bit after the data bits.
REQ-003 Parameter PARITY_ODD, default 0, 0 selects even parity and 1 selects odd parity.
REQ-004 Parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 baud_tick  input  1  one-clk pulse per bit period from the external baud generator.
REQ-008 baud_clr  output  1  one-clk pulse that restarts the external baud generator's count.
REQ-009 req0_valid  input  1  requester 0 has a byte.
REQ-010 req0_data  input  DATA_W  requester 0 byte.
REQ-011 req0_ready  output  1  requester 0 byte accepted this cycle.
REQ-012 req1_valid, req1_data, req1_ready  same widths and meaning as REQ-009..011 for requester 1.
REQ-013 tx  output  1  serial line, idle high.
REQ-014 busy  output  1  frame in progress.
REQ-015 grant_id  output  1  index of the most recently accepted requester.

Function
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY SHALL be skipped when PARITY_EN=0.
REQ-017 reqN_ready SHALL be combinational: high only in IDLE and only for the requester the arbiter selects; at most one ready high per cycle.
REQ-018 Arbiter rule: only one valid -> select it; both valid -> select the requester that is not grant_id (round-robin); after reset, requester 0 wins a tie.
REQ-019 Handshake SHALL complete on the edge where valid && ready; the requester holds valid and data stable until then; valid dropped before ready is no transfer.
REQ-020 On the handshake edge: data latched, grant_id updated, state -> START, tx <= 0, baud_clr <= 1 for exactly one cycle.
REQ-021 START: on baud_tick, tx <= data bit 0 and state -> DATA.
REQ-022 DATA: on each baud_tick, advance one bit; after DATA_W ticks in total from START, drive the parity bit (or stop level 1) and move to PARITY or STOP.
REQ-023 Parity bit = XOR of the latched data bits, inverted when PARITY_ODD=1.
REQ-024 STOP: tx = 1; after STOP_BITS baud_ticks, state -> IDLE.
REQ-025 Frame length SHALL be 1+DATA_W+PARITY_EN+STOP_BITS bit periods; tx changes only on handshake edges and baud_tick edges.
REQ-026 baud_tick SHALL be ignored in IDLE; a baud_tick coincident with the handshake edge SHALL be ignored.
REQ-027 The earliest next handshake SHALL be the cycle after the return to IDLE (minimum one idle clk between frames).
REQ-028 busy SHALL be high in every state except IDLE; tx and busy SHALL be registered outputs.
REQ-029 New valid/data changes during a frame SHALL NOT alter the latched byte or the tx waveform.

Reset
REQ-030 While rst_n=0 at a clk edge: state=IDLE, tx=1, busy=0, baud_clr=0, grant_id=1 (so requester 0 wins the first tie), shift and bit counters=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame: tx=1 on the next edge with no further bits; the aborted byte is discarded; reqN_ready=0 while rst_n=0.

Verification
REQ-032 Single byte: PARITY_EN=0, STOP_BITS=1, req0 sends 0xA5 with baud_tick every 16 clks -> one baud_clr pulse, tx = 0,1,0,1,0,0,1,0,1,1, one bit per tick; busy drops after the stop tick.
REQ-033 Tie: both valid from reset, req0=0x11, req1=0x22 held -> frames 0x11 then 0x22; grant_id 0 then 1; next tie goes to req0.
REQ-034 Parity: PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1; PARITY_ODD=1 -> 0; STOP_BITS=2 -> two stop periods high.
REQ-035 Back-to-back: req1 valid continuously with 0x3C, 0xC3 -> second ready exactly one clk after busy falls; no glitch on tx between frames.
REQ-036 Reset mid-DATA after 3 ticks -> tx=1 and busy=0 on the next edge; first post-reset handshake starts a clean frame.
REQ-037 Ticks in IDLE, and a tick coincident with the handshake -> no tx change; the start bit lasts until the next tick.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: two-requester round-robin UART transmitter.
// Frames are start + DATA_W data bits (LSB first) + optional parity + stop bits.
//
// Ports:
//   clk, rst_n        system clock, synchronous active-low reset
//   baud_tick         one-clk pulse per bit period from the baud generator
//   baud_clr          one-clk pulse that restarts the baud generator at frame start
//   reqN_valid/data   requester N offers a byte (N = 0, 1)
//   reqN_ready        requester N's byte is accepted this cycle (combinational)
//   tx                serial line, idle high (registered)
//   busy              frame in progress (registered)
//   grant_id          index of the most recently accepted requester
module uart_tx_sched #(
    parameter int unsigned DATA_W     = 8,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              baud_tick,
    output logic              baud_clr,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              tx,
    output logic              busy,
    output logic              grant_id
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_nx;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_cnt_nx;
    logic              par_bit;
    logic              par_nx;
    logic              tx_nx;
    logic              busy_nx;
    logic              clr_nx;
    logic              grant_nx;

    logic              sel;
    logic              any_valid;
    logic              idle_ok;
    logic [DATA_W-1:0] sel_data;

    // Lone requester wins; on a tie, the one not granted last time wins.
    assign any_valid = req0_valid | req1_valid;
    assign sel       = req1_valid & (~req0_valid | ~grant_id);
    assign sel_data  = sel ? req1_data : req0_data;

    // Ready is gated by rst_n so nothing is accepted while held in reset.
    assign idle_ok    = (state == IDLE) & rst_n;
    assign req0_ready = idle_ok & req0_valid & ~sel;
    assign req1_ready = idle_ok & sel;

    always_comb begin
        state_nx   = state;
        shift_nx   = shift;
        bit_cnt_nx = bit_cnt;
        par_nx     = par_bit;
        tx_nx      = tx;
        clr_nx     = 1'b0;
        grant_nx   = grant_id;

        unique case (state)
            IDLE: begin
                // baud_tick is deliberately ignored here and on the
                // handshake edge; the start bit lasts until the next tick.
                if (any_valid) begin
                    state_nx   = START;
                    shift_nx   = sel_data;
                    par_nx     = (^sel_data) ^ PARITY_ODD;
                    grant_nx   = sel;
                    tx_nx      = 1'b0;
                    clr_nx     = 1'b1;
                    bit_cnt_nx = '0;
                end
            end
            START: begin
                if (baud_tick) begin
                    tx_nx      = shift[0];
                    shift_nx   = shift >> 1;
                    bit_cnt_nx = CNT_ONE;
                    state_nx   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_nx = '0;
                        if (PARITY_EN) begin
                            tx_nx    = par_bit;
                            state_nx = PARITY;
                        end else begin
                            tx_nx    = 1'b1;
                            state_nx = STOP;
                        end
                    end else begin
                        tx_nx      = shift[0];
                        shift_nx   = shift >> 1;
                        bit_cnt_nx = bit_cnt + CNT_ONE;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    tx_nx      = 1'b1;
                    bit_cnt_nx = '0;
                    state_nx   = STOP;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (bit_cnt == LAST_STOP) begin
                        bit_cnt_nx = '0;
                        state_nx   = IDLE;
                    end else begin
                        bit_cnt_nx = bit_cnt + CNT_ONE;
                    end
                end
            end
            default: begin
                tx_nx    = 1'b1;
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            baud_clr <= 1'b0;
            grant_id <= 1'b1;
        end else begin
            state    <= state_nx;
            shift    <= shift_nx;
            bit_cnt  <= bit_cnt_nx;
            par_bit  <= par_nx;
            tx       <= tx_nx;
            busy     <= busy_nx;
            baud_clr <= clr_nx;
            grant_id <= grant_nx;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed checks of uart_tx_sched framing and arbitration.
// Three instances: plain 8N1, even parity + 2 stop, odd parity + 1 stop.
module tb_uart_tx_sched;

    logic       clk;
    logic       rst_n;
    logic       baud_tick;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req1_valid;
    logic [7:0] req1_data;

    logic clr_d, r0_d, r1_d, tx_d, busy_d, gid_d;
    logic clr_e, r0_e, r1_e, tx_e, busy_e, gid_e;
    logic clr_o, r0_o, r1_o, tx_o, busy_o, gid_o;

    // tx level after tick k sits in bit k-1; trailing ones are stop/idle.
    localparam logic [9:0]  E_D = {2'b11, 8'h07};
    localparam logic [10:0] E_O = {3'b110, 8'h07};
    localparam logic [11:0] E_E = {4'b1111, 8'h07};

    int n_vec = 0;
    int n_bad = 0;

    uart_tx_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_tick  (baud_tick),
        .baud_clr   (clr_d),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (r0_d),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (r1_d),
        .tx         (tx_d),
        .busy       (busy_d),
        .grant_id   (gid_d)
    );

    uart_tx_sched #(
        .PARITY_EN  (1'b1),
        .PARITY_ODD (1'b0),
        .STOP_BITS  (2)
    ) dut_e (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_tick  (baud_tick),
        .baud_clr   (clr_e),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (r0_e),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (r1_e),
        .tx         (tx_e),
        .busy       (busy_e),
        .grant_id   (gid_e)
    );

    uart_tx_sched #(
        .PARITY_EN  (1'b1),
        .PARITY_ODD (1'b1),
        .STOP_BITS  (1)
    ) dut_o (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_tick  (baud_tick),
        .baud_clr   (clr_o),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (r0_o),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (r1_o),
        .tx         (tx_o),
        .busy       (busy_o),
        .grant_id   (gid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        baud_tick = 1'b1;
        cyc();
        baud_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        baud_tick  = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    // Plain-instance frame after the handshake: 16-clk bit periods,
    // mid-period hold checks, then the level and busy after each tick.
    task automatic run_frame(input string tag, input logic [7:0] b);
        logic lvl;
        lvl = 1'b0;
        for (int i = 0; i < 10; i++) begin
            repeat (8) cyc();
            chk({tag, "/hold"}, tx_d, lvl);
            chk({tag, "/rdy"}, {r0_d, r1_d}, 2'b00);
            chk({tag, "/clr"}, clr_d, 1'b0);
            repeat (7) cyc();
            tick();
            lvl = (i < 8) ? b[i] : 1'b1;
            chk({tag, "/bit"}, tx_d, lvl);
            chk({tag, "/busy"}, busy_d, (i < 9));
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        baud_tick  = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 8'h11;
        req1_valid = 1'b1;
        req1_data  = 8'h22;
        cyc();
        cyc();
        chk("rst/tx", tx_d, 1'b1);
        chk("rst/busy", busy_d, 1'b0);
        chk("rst/clr", clr_d, 1'b0);
        chk("rst/gid", gid_d, 1'b1);
        chk("rst/rdy", {r0_d, r1_d}, 2'b00);

        // Tie from reset: req0 first, then req1, then req0 again.
        rst_n = 1'b1;
        #1;
        chk("tie0/rdy", {r0_d, r1_d}, 2'b10);
        cyc();
        chk("tie0/gid", gid_d, 1'b0);
        chk("tie0/tx", tx_d, 1'b0);
        chk("tie0/busy", busy_d, 1'b1);
        chk("tie0/clr", clr_d, 1'b1);
        run_frame("tie0", 8'h11);
        chk("tie1/rdy", {r0_d, r1_d}, 2'b01);
        cyc();
        chk("tie1/gid", gid_d, 1'b1);
        chk("tie1/tx", tx_d, 1'b0);
        run_frame("tie1", 8'h22);
        chk("tie2/rdy", {r0_d, r1_d}, 2'b10);
        cyc();
        chk("tie2/gid", gid_d, 1'b0);

        // Single byte; tick in IDLE and tick on the handshake edge.
        do_reset();
        tick();
        chk("idle/tx", tx_d, 1'b1);
        chk("idle/busy", busy_d, 1'b0);
        req0_valid = 1'b1;
        req0_data  = 8'hA5;
        baud_tick  = 1'b1;
        #1;
        chk("a5/rdy", {r0_d, r1_d}, 2'b10);
        cyc();
        baud_tick  = 1'b0;
        req0_valid = 1'b0;
        req0_data  = 8'hFF;
        chk("a5/tx", tx_d, 1'b0);
        chk("a5/busy", busy_d, 1'b1);
        chk("a5/clr", clr_d, 1'b1);
        chk("a5/gid", gid_d, 1'b0);
        cyc();
        chk("a5/clr1", clr_d, 1'b0);
        chk("a5/tickign", tx_d, 1'b0);
        run_frame("a5", 8'hA5);

        // Parity and stop-bit variants on byte 0x07.
        do_reset();
        req0_valid = 1'b1;
        req0_data  = 8'h07;
        cyc();
        req0_valid = 1'b0;
        chk("par/start", {tx_d, tx_e, tx_o}, 3'b000);
        for (int i = 0; i < 12; i++) begin
            repeat (15) cyc();
            tick();
            if (i < 10) begin
                chk("par/d_tx", tx_d, E_D[i]);
                chk("par/d_busy", busy_d, (i < 9));
            end
            if (i < 11) begin
                chk("par/o_tx", tx_o, E_O[i]);
                chk("par/o_busy", busy_o, (i < 10));
            end
            chk("par/e_tx", tx_e, E_E[i]);
            chk("par/e_busy", busy_e, (i < 11));
        end

        // Back-to-back from req1; data changes mid-frame are ignored.
        do_reset();
        req1_valid = 1'b1;
        req1_data  = 8'h3C;
        #1;
        chk("b2b/rdy0", {r0_d, r1_d}, 2'b01);
        cyc();
        chk("b2b/gid", gid_d, 1'b1);
        chk("b2b/tx0", tx_d, 1'b0);
        req1_data = 8'hC3;
        run_frame("b2b0", 8'h3C);
        chk("b2b/rdy1", {r0_d, r1_d}, 2'b01);
        chk("b2b/gap", tx_d, 1'b1);
        cyc();
        req1_valid = 1'b0;
        chk("b2b/tx1", tx_d, 1'b0);
        chk("b2b/busy1", busy_d, 1'b1);
        chk("b2b/clr1", clr_d, 1'b1);
        run_frame("b2b1", 8'hC3);

        // Reset after three ticks of a 0x5A frame, then a clean frame.
        do_reset();
        req0_valid = 1'b1;
        req0_data  = 8'h5A;
        cyc();
        chk("abt/tx0", tx_d, 1'b0);
        for (int i = 0; i < 3; i++) begin
            repeat (15) cyc();
            tick();
        end
        chk("abt/pre_tx", tx_d, 1'b0);
        chk("abt/pre_busy", busy_d, 1'b1);
        repeat (4) cyc();
        rst_n = 1'b0;
        cyc();
        chk("abt/tx", tx_d, 1'b1);
        chk("abt/busy", busy_d, 1'b0);
        chk("abt/rdy", {r0_d, r1_d}, 2'b00);
        rst_n     = 1'b1;
        req0_data = 8'hA5;
        #1;
        chk("abt/rdy1", {r0_d, r1_d}, 2'b10);
        cyc();
        req0_valid = 1'b0;
        chk("abt/tx1", tx_d, 1'b0);
        chk("abt/busy1", busy_d, 1'b1);
        chk("abt/clr1", clr_d, 1'b1);
        chk("abt/gid1", gid_d, 1'b0);
        run_frame("abt", 8'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
